// File: rtl/risc_prog_loader.sv
// Streams a 16-bit program image into the core's memory from address 0 and holds
// the core in reset until the load completes. Optional macro LOADER_CLEAR_EN zero-fills memory first.
module risc_prog_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              s_valid_i,
    input  logic [15:0]       s_data_i,
    input  logic              s_last_i,
    output logic              s_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [15:0]       mem_wdata_o,
    output logic              cpu_rst_no,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W:0]   word_cnt_o,
    output logic [15:0]       csum_o
);

`ifdef LOADER_CLEAR_EN
    typedef enum logic [2:0] {ST_IDLE, ST_CLEAR, ST_LOAD, ST_FLUSH, ST_DONE, ST_ERR} state_e;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_FLUSH, ST_DONE, ST_ERR} state_e;
`endif

    localparam logic [ADDR_W:0] LAST_SLOT = {1'b0, {ADDR_W{1'b1}}};

    state_e            state_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [15:0]       mem_wdata_q;
    logic              cpu_rst_n_q;
    logic              done_q;
    logic              err_q;
    logic [ADDR_W:0]   word_cnt_q;
    logic [15:0]       csum_q;
`ifdef LOADER_CLEAR_EN
    logic [ADDR_W-1:0] clr_addr_q;
`endif

    logic            accept_d;
    logic [ADDR_W:0] word_cnt_d;
    logic [15:0]     csum_d;

    // Ready is a pure state decode, so there is no path from s_valid_i to s_ready_o.
    assign s_ready_o = (state_q == ST_LOAD);

    always_comb begin
        accept_d   = s_ready_o & s_valid_i;
        word_cnt_d = word_cnt_q + (ADDR_W+1)'(1);
        csum_d     = csum_q + s_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rst_n_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            word_cnt_q  <= '0;
            csum_q      <= '0;
`ifdef LOADER_CLEAR_EN
            clr_addr_q  <= '0;
`endif
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start_i) begin
                        word_cnt_q  <= '0;
                        csum_q      <= '0;
                        done_q      <= 1'b0;
                        err_q       <= 1'b0;
                        cpu_rst_n_q <= 1'b0;
`ifdef LOADER_CLEAR_EN
                        clr_addr_q  <= '0;
                        state_q     <= ST_CLEAR;
`else
                        state_q     <= ST_LOAD;
`endif
                    end
                end
`ifdef LOADER_CLEAR_EN
                ST_CLEAR: begin
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= clr_addr_q;
                    mem_wdata_q <= '0;
                    clr_addr_q  <= clr_addr_q + ADDR_W'(1);
                    if (clr_addr_q == {ADDR_W{1'b1}}) begin
                        state_q <= ST_LOAD;
                    end
                end
`endif
                ST_LOAD: begin
                    if (accept_d) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= word_cnt_q[ADDR_W-1:0];
                        mem_wdata_q <= s_data_i;
                        word_cnt_q  <= word_cnt_d;
                        csum_q      <= csum_d;
                        // Last word wins over overflow when both land on the top slot.
                        if (s_last_i) begin
                            state_q <= ST_FLUSH;
                        end else if (word_cnt_q == LAST_SLOT) begin
                            err_q   <= 1'b1;
                            state_q <= ST_ERR;
                        end
                    end
                end
                ST_FLUSH: begin
                    done_q      <= 1'b1;
                    cpu_rst_n_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign cpu_rst_no  = cpu_rst_n_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign word_cnt_o  = word_cnt_q;
    assign csum_o      = csum_q;

endmodule

// File: tb/tb_risc_prog_loader.sv
// Bench for risc_prog_loader: directed and random image sessions checked against
// image-level expectations (accepted count, wrap-around sum, write order and timing).
module tb_risc_prog_loader;

    localparam int ADDR_W = 3;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rstN;
    logic              start;
    logic              sValid;
    logic [15:0]       sData;
    logic              sLast;
    logic              sReady;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [15:0]       memWdata;
    logic              cpuRstN;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   wordCnt;
    logic [15:0]       csum;

    int total = 0;
    int bad   = 0;
    logic [15:0] img[$];

    risc_prog_loader #(.ADDR_W(ADDR_W)) dut (
        .clk_i      (clk),
        .rst_ni     (rstN),
        .start_i    (start),
        .s_valid_i  (sValid),
        .s_data_i   (sData),
        .s_last_i   (sLast),
        .s_ready_o  (sReady),
        .mem_we_o   (memWe),
        .mem_addr_o (memAddr),
        .mem_wdata_o(memWdata),
        .cpu_rst_no (cpuRstN),
        .done_o     (done),
        .err_o      (err),
        .word_cnt_o (wordCnt),
        .csum_o     (csum)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_ready"}, sReady, 0);
        checkOutput({tag, "_we"}, memWe, 0);
        checkOutput({tag, "_addr"}, memAddr, 0);
        checkOutput({tag, "_wdata"}, memWdata, 0);
        checkOutput({tag, "_cpuRstN"}, cpuRstN, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_err"}, err, 0);
        checkOutput({tag, "_cnt"}, wordCnt, 0);
        checkOutput({tag, "_csum"}, csum, 0);
    endtask

    task automatic checkWrite(input bit expWe, input logic [ADDR_W-1:0] expAddr, input logic [15:0] expData);
        checkOutput("we", memWe, expWe);
        if (expWe) begin
            checkOutput("addr", memAddr, expAddr);
            checkOutput("wdata", memWdata, expData);
        end
    endtask

    // One session: start, optional clear phase, stream img with random gaps, then check completion.
    task automatic applyStimulus(input int len, input bit withLast, input int gapPct);
        bit                expErr;
        int                expAcc;
        logic [15:0]       expSum;
        int                k;
        int                cyc;
        bit                pendWe;
        logic [ADDR_W-1:0] pendAddr;
        logic [15:0]       pendData;
        bit                valid;

        expErr = !(withLast && len <= DEPTH);
        expAcc = expErr ? DEPTH : len;
        expSum = '0;
        for (int i = 0; i < expAcc; i++) expSum += img[i];

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("startCnt", wordCnt, 0);
        checkOutput("startCsum", csum, 0);
        checkOutput("startDone", done, 0);
        checkOutput("startErr", err, 0);
        checkOutput("startCpu", cpuRstN, 0);
        pendWe   = 1'b0;
        pendAddr = '0;
        pendData = '0;
`ifdef LOADER_CLEAR_EN
        for (int i = 0; i < DEPTH; i++) begin
            checkOutput("clrReady", sReady, 0);
            checkWrite(i > 0, ADDR_W'(i - 1), 16'h0000);
            start = (i == 1);
            @(posedge clk); #1;
        end
        start    = 1'b0;
        pendWe   = 1'b1;
        pendAddr = ADDR_W'(DEPTH - 1);
        pendData = 16'h0000;
`endif
        k   = 0;
        cyc = 0;
        while (k < expAcc && cyc < 300) begin
            checkOutput("ready", sReady, 1);
            checkWrite(pendWe, pendAddr, pendData);
            valid  = ($urandom_range(99) >= gapPct);
            sValid = valid;
            sData  = valid ? img[k] : 16'($urandom);
            sLast  = valid ? (withLast && k == len - 1) : 1'($urandom_range(1));
            @(posedge clk); #1;
            cyc++;
            pendWe = valid;
            if (valid) begin
                pendAddr = k[ADDR_W-1:0];
                pendData = img[k];
                k++;
            end
        end
        checkOutput("acceptedBeforeBudget", k, expAcc);

        // Offer one more beat; it must not be taken after the final or overflow word.
        sValid = 1'b1;
        sData  = 16'($urandom);
        sLast  = 1'b0;
        checkWrite(pendWe, pendAddr, pendData);
        checkOutput("endCnt", wordCnt, expAcc);
        checkOutput("endCsum", csum, expSum);
        checkOutput("endReady", sReady, 0);
        checkOutput("endCpu", cpuRstN, 0);
        checkOutput("endErr", err, expErr);
        checkOutput("endDone", done, 0);
        @(posedge clk); #1;
        checkOutput("postWe", memWe, 0);
        checkOutput("postCnt", wordCnt, expAcc);
        checkOutput("postDone", done, !expErr);
        checkOutput("postCpu", cpuRstN, !expErr);
        checkOutput("postErr", err, expErr);
        checkOutput("postReady", sReady, 0);
        sValid = 1'b0;
        @(posedge clk); #1;
        checkOutput("holdDone", done, !expErr);
        checkOutput("holdCsum", csum, expSum);
    endtask

    initial begin
        int len;
        bit withLast;

        rstN   = 1'b0;
        start  = 1'b0;
        sValid = 1'b1;
        sData  = 16'hFFFF;
        sLast  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkReset("rst");
        rstN = 1'b1;
        @(posedge clk); #1;
        checkReset("idle");
        sValid = 1'b0;

        img = '{16'h7888, 16'hA18F, 16'h5108};
        applyStimulus(3, 1'b1, 0);
        checkOutput("basicCsum", csum, 16'h6B1F);

        applyStimulus(3, 1'b1, 50);
        checkOutput("gapCsum", csum, 16'h6B1F);

        img = {};
        for (int i = 1; i <= DEPTH + 1; i++) img.push_back(16'(i));
        applyStimulus(DEPTH + 1, 1'b0, 0);
        checkOutput("ovfCsum", csum, 16'(DEPTH * (DEPTH + 1) / 2));

        img = {};
        for (int i = 0; i < DEPTH; i++) img.push_back(16'($urandom));
        applyStimulus(DEPTH, 1'b1, 30);

        img = '{16'h7888, 16'hA18F, 16'h5108};
        start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        sValid = 1'b1;
        sLast  = 1'b0;
        sData  = img[0];
        @(posedge clk); #1;
        sData = img[1];
        @(posedge clk); #1;
        rstN = 1'b0;
        #1;
        checkReset("midRst");
        @(posedge clk); #1;
        checkReset("midRstHeld");
        rstN   = 1'b1;
        sValid = 1'b0;
        applyStimulus(3, 1'b1, 0);
        checkOutput("reloadCnt", wordCnt, 3);
        checkOutput("reloadCsum", csum, 16'h6B1F);

        for (int s = 0; s < 6; s++) begin
            len      = int'($urandom_range(12, 1));
            withLast = 1'($urandom_range(1));
            if (!withLast && len <= DEPTH) withLast = 1'b1;
            img = {};
            for (int i = 0; i < len; i++) img.push_back(16'($urandom));
            applyStimulus(len, withLast, int'($urandom_range(60)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/risc_prog_loader.md
# risc_prog_loader

Program/data image loader sitting directly upstream of the `risc_16_bit` core's unified 16-bit memory. It accepts a stream of 16-bit words over a valid/ready handshake and writes them to consecutive memory addresses from 0. It holds the core in reset until the image is fully written. It reports word count, a 16-bit additive checksum, and overflow. It replaces hierarchical memory preloading from benches with a synthesizable load path.

## Interface
- `ADDR_W`, 8: memory address width; depth = 2^ADDR_W words.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; begins a load session (honoured only in IDLE, DONE, ERR).
- `s_valid` in 1: upstream word valid.
- `s_data` in 16: upstream word.
- `s_last` in 1: qualifies `s_data` as the final word of the image.
- `s_ready` out 1: loader accepts a word this cycle.
- `mem_we` out 1: memory write enable, registered.
- `mem_addr` out ADDR_W: write address, registered.
- `mem_wdata` out 16: write data, registered.
- `cpu_rst_n` out 1: active-low reset to the core; low while loading.
- `done` out 1: image loaded and core released.
- `err` out 1: image overflowed the memory depth.
- `word_cnt` out ADDR_W+1: words accepted this session.
- `csum` out 16: sum of accepted words, modulo 2^16.

## Operation
- States: IDLE, CLEAR (macro only), LOAD, FLUSH, DONE, ERR.
- Reset state:
  - FSM in IDLE.
  - `cpu_rst_n`=0, `s_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `done`=0, `err`=0, `word_cnt`=0, `csum`=0.
- IDLE or DONE or ERR, on `start`:
  - Clear `word_cnt`, `csum`, `done`, `err`.
  - Drive `cpu_rst_n`=0.
  - Go to CLEAR if compiled in, else LOAD.
- LOAD:
  - `s_ready`=1.
  - A beat is accepted when `s_valid & s_ready`. On acceptance: write `s_data` at address `word_cnt[ADDR_W-1:0]`, increment `word_cnt`, add `s_data` to `csum` (carry discarded).
  - Accepted `s_last` goes to FLUSH.
  - Accepted beat with `word_cnt` = 2^ADDR_W−1 and no `s_last`: the word is written, then go to ERR.
- FLUSH: one cycle, `s_ready`=0, then DONE.
- DONE: `done`=1, `cpu_rst_n`=1, `s_ready`=0.
- ERR: `err`=1, `cpu_rst_n`=0, `s_ready`=0. The core is never released on a bad image.
- `start` in CLEAR, LOAD or FLUSH is ignored.
- `s_data`/`s_last` are ignored when `s_valid`=0.
- `mem_we` is 0 in every cycle without a write.

## Timing
- Write latency is 1: a beat accepted at edge N appears on `mem_we`/`mem_addr`/`mem_wdata` from N to N+1.
- `word_cnt` and `csum` update at the acceptance edge.
- The last beat is accepted at edge N. FLUSH covers N to N+1. DONE is entered at N+1, so `cpu_rst_n` and `done` rise at N+1, after the last write is committed.
- Throughput is one word per cycle under continuous `s_valid`.
- `s_ready` depends only on state. It has no combinational path from `s_valid`.
- ERR is entered at the overflow acceptance edge; `err` rises at that edge.
- `rst_n` low at any time, including mid-CLEAR or mid-LOAD, forces all outputs to their reset values immediately. The partial image is abandoned and the core stays in reset.

## Configuration
- Macro `LOADER_CLEAR_EN`.
- Defined:
  - CLEAR zero-fills addresses 0..2^ADDR_W−1, one write per cycle, with `s_ready`=0.
  - Exactly 2^ADDR_W cycles, then LOAD.
  - `word_cnt`/`csum` are not affected.
- Undefined:
  - No CLEAR state.
  - `start` goes straight to LOAD.
  - Locations not written keep prior contents.

## Test plan
- Reset check: hold `rst_n`=0 -> all outputs at reset values; `cpu_rst_n`=0; `s_valid`=1 is not accepted.
- Basic load: `start`, then 0x7888, 0xA18F, 0x5108 (last on third), back-to-back ->
  - writes to addr 0,1,2, each one cycle after acceptance;
  - `word_cnt`=3, `csum`=0x6B1F;
  - `done`=`cpu_rst_n`=1 one cycle after the last `mem_we`.
- Backpressure/gaps: same image with `s_valid` toggling 1,0,0,1,0,1 -> identical writes and `csum` 0x6B1F; no write in idle cycles.
- Overflow: `ADDR_W`=2, five words 1..5, never last ->
  - words 1..4 written to addr 0..3;
  - `err`=1, `word_cnt`=4, `csum`=0x000A;
  - `cpu_rst_n` stays 0; fifth word not accepted.
- Reset mid-load: drop `rst_n` after 2 of 3 words -> immediate reset values; a new `start` plus 3 words gives `word_cnt`=3, `csum`=0x6B1F.
- `LOADER_CLEAR_EN`, `ADDR_W`=3: `start` -> 8 zero writes to addr 0..7 with `s_ready`=0, then LOAD; `start` pulsed during CLEAR is ignored.
